// File: rtl/bfly7681s.sv
// bfly7681s: signed Cooley-Tukey butterfly back-end mod 7681 with valid pipeline and frame counter.
// Optional BFLY7681_HALF_EN: scales both results by 2^-1 mod 7681 before the output register.
module bfly7681s #(
    parameter int MUL_LAT = 4,
    parameter int NBFLY   = 128,
    parameter int IDX_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [12:0]      inA,
    input  logic signed [12:0]      inWB,
    output logic                    out_valid,
    output logic signed [12:0]      outP,
    output logic signed [12:0]      outM,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_last
);
    localparam logic signed [13:0] Q = 14'sd7681;
    localparam logic signed [13:0] H = 14'sd3840;

    logic [MUL_LAT-1:0]  v_pipe;
    logic signed [12:0]  a_pipe [MUL_LAT];
    logic [IDX_W-1:0]    cnt;
    logic                v_d;
    logic signed [12:0]  a_d;
    logic signed [12:0]  p_n;
    logic signed [12:0]  m_n;
    logic                wrap;

    // Sums lie in [-7680, 7680], so a single add or subtract of Q re-centres them.
    function automatic logic signed [13:0] fold(input logic signed [13:0] s);
        return s > H ? s - Q : (s < -H ? s + Q : s);
    endfunction

    // Halving mod Q: odd values are first moved by Q to make them even.
    function automatic logic signed [13:0] scale(input logic signed [13:0] r);
`ifdef BFLY7681_HALF_EN
        return !r[0] ? r >>> 1 : (r > 0 ? (r - Q) >>> 1 : (r + Q) >>> 1);
`else
        return r;
`endif
    endfunction

    assign v_d  = v_pipe[MUL_LAT-1];
    assign a_d  = a_pipe[MUL_LAT-1];
    assign wrap = cnt == IDX_W'(NBFLY - 1);

    // Valid bits of the delay line; cleared on reset so in-flight launches are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe <= '0;
        end else begin
            v_pipe[0] <= in_valid;
            for (int k = 1; k < MUL_LAT; k++) v_pipe[k] <= v_pipe[k-1];
        end
    end

    // Operand a travels alongside its valid bit to meet the multiplier product.
    always_ff @(posedge clk) begin
        a_pipe[0] <= inA;
        for (int k = 1; k < MUL_LAT; k++) a_pipe[k] <= a_pipe[k-1];
    end

    // Sum and difference, re-centred and optionally halved.
    always_comb begin
        p_n = 13'(scale(fold(14'(a_d) + 14'(inWB))));
        m_n = 13'(scale(fold(14'(a_d) - 14'(inWB))));
    end

    // Output register and per-frame butterfly counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            outP      <= '0;
            outM      <= '0;
            out_idx   <= '0;
            cnt       <= '0;
        end else begin
            out_valid <= v_d;
            out_last  <= v_d && wrap;
            if (v_d) begin
                outP    <= p_n;
                outM    <= m_n;
                out_idx <= cnt;
                cnt     <= wrap ? '0 : cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bfly7681s.sv
// tb_bfly7681s: directed-vector bench for bfly7681s (MUL_LAT=4, NBFLY=4); define BFLY7681_HALF_EN for scaled checks.
module tb_bfly7681s;
    localparam int MUL_LAT = 4;
    localparam int NBFLY   = 4;
    localparam int IDX_W   = 2;

    typedef struct {
        bit r;
        bit v;
        int a;
        int wb;
        int p;
        int m;
        int idx;
        bit last;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic signed [12:0] inA = '0;
    logic signed [12:0] inWB = '0;
    logic out_valid;
    logic signed [12:0] outP;
    logic signed [12:0] outM;
    logic [IDX_W-1:0] out_idx;
    logic out_last;

    int n_chk = 0;
    int n_pass = 0;
    bit zero_hold = 1'b1;
    vec_t tbl[$];
    vec_t hist[MUL_LAT+1];

    bfly7681s #(.MUL_LAT(MUL_LAT), .NBFLY(NBFLY), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .inA(inA), .inWB(inWB),
        .out_valid(out_valid), .outP(outP), .outM(outM), .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int modc(input longint x);
        longint r;
        r = x % 7681;
        if (r > 3840) r -= 7681;
        else if (r < -3840) r += 7681;
        return int'(r);
    endfunction

    function automatic void row(input bit r, input bit v, input int a, input int wb,
                                input int p, input int m, input int idx, input bit last);
        vec_t t;
        t.r = r; t.v = v; t.a = a; t.wb = wb; t.p = p; t.m = m; t.idx = idx; t.last = last;
        tbl.push_back(t);
    endfunction

    function automatic void idle(input int n);
        for (int i = 0; i < n; i++) row(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // One cycle: check outputs against the launch made MUL_LAT+1 cycles earlier, then drive.
    task automatic cycle(input vec_t t);
        vec_t e;
        @(negedge clk);
        e = hist[MUL_LAT];
        chk("out_valid", int'(out_valid), int'(e.v));
        if (e.v) begin
            chk("outP", int'(outP), e.p);
            chk("outM", int'(outM), e.m);
            chk("out_idx", int'(out_idx), e.idx);
            chk("out_last", int'(out_last), int'(e.last));
            zero_hold = 1'b0;
        end else begin
            chk("out_last_idle", int'(out_last), 0);
            if (zero_hold) begin
                chk("outP_rst", int'(outP), 0);
                chk("outM_rst", int'(outM), 0);
                chk("out_idx_rst", int'(out_idx), 0);
            end
        end
`ifdef BFLY7681_HALF_EN
        t.p = modc(longint'(t.a + t.wb) * 3841);
        t.m = modc(longint'(t.a - t.wb) * 3841);
`endif
        for (int k = MUL_LAT; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = t;
        if (t.r) begin
            for (int k = 0; k <= MUL_LAT; k++) hist[k].v = 1'b0;
            zero_hold = 1'b1;
        end
        rst = t.r;
        in_valid = t.v;
        inA = 13'(t.a);
        inWB = 13'(hist[MUL_LAT].wb);
    endtask

    initial begin
        for (int k = 0; k <= MUL_LAT; k++) hist[k] = '{default: 0};
        // reset with in_valid toggling
        row(1, 1, 5, 5, 0, 0, 0, 0);
        row(1, 0, 0, 0, 0, 0, 0, 0);
        row(1, 1, 7, 7, 0, 0, 0, 0);
        idle(6);
        // overflow wrap, isolated so latency is exact
        row(0, 1, 3840, 3840, -1, 0, 0, 0);
        idle(5);
        // wrap/boundary vectors, one gap
        row(0, 1, -3840, 3840, 0, 1, 1, 0);
        row(0, 1, 100, -200, -100, 300, 2, 0);
        row(0, 1, -3840, -3840, 1, 0, 3, 1);
        row(0, 1, 1234, 567, 1801, 667, 0, 0);
        idle(1);
        row(0, 1, 3000, -2000, 1000, -2681, 1, 0);
        row(0, 1, -3000, 2000, -1000, 2681, 2, 0);
        row(0, 1, 3840, 0, 3840, 3840, 3, 1);
        row(0, 1, -3840, 0, -3840, -3840, 0, 0);
        row(0, 1, 2000, 1841, -3840, 159, 1, 0);
        idle(6);
        // frame counting from a fresh reset
        row(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        row(0, 1, 10, 1, 11, 9, 0, 0);
        row(0, 1, 20, 1, 21, 19, 1, 0);
        idle(1);
        row(0, 1, 30, 1, 31, 29, 2, 0);
        row(0, 1, 40, 1, 41, 39, 3, 1);
        row(0, 1, 50, 1, 51, 49, 0, 0);
        row(0, 1, 60, 1, 61, 59, 1, 0);
        idle(6);
        // reset mid-flight
        row(0, 1, 70, 1, 71, 69, 2, 0);
        row(0, 1, 80, 1, 81, 79, 3, 1);
        idle(1);
        row(1, 0, 0, 0, 0, 0, 0, 0);
        idle(6);
        row(0, 1, 5, 5, 10, 0, 0, 0);
        idle(6);
`ifdef BFLY7681_HALF_EN
        row(0, 1, 1, 0, -3840, -3840, 1, 0);
        row(0, 1, 2, 0, 1, 1, 2, 0);
        for (int i = 0; i <= 80; i++)
            for (int j = 0; j <= 60; j++) begin
                int n;
                n = (3 + i * 61 + j) % NBFLY;
                row(0, 1, -3840 + 96 * i, -3840 + 128 * j, 0, 0, n, n == NBFLY - 1);
            end
        idle(6);
`endif
        foreach (tbl[i]) cycle(tbl[i]);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
